// File: rtl/branch_cond_unit.sv
// Branch condition unit: accepts a branch request, waits out any in-progress PSR
// flag update, evaluates the condition code against the flags, and reports the
// resolved next fetch address together with a saturating taken-branch count.
module branch_cond_unit #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [3:0]       br_cond,
   input  logic [15:0]      br_pc,
   input  logic [15:0]      br_disp,
   input  logic [4:0]       flag_in,
   input  logic             psr_wr,
   input  logic             flush,
   output logic             res_valid,
   output logic             res_taken,
   output logic [15:0]      res_pc,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {
      StIdle,
      StWaitFlags,
      StResolve
   } state_e;

   state_e      state_q, state_d;
   logic        accept;
   logic        resolve;
   logic [3:0]  cond_q;
   logic [15:0] pc_q;
   logic [15:0] disp_q;
   logic        cond_met;
   logic [15:0] target;

   // Flag bits, ordered {F,L,C,N,Z} on flag_in
   logic flg_f, flg_l, flg_c, flg_n, flg_z;
   assign {flg_f, flg_l, flg_c, flg_n, flg_z} = flag_in;

   assign br_ready = (state_q == StIdle);

   // Next-state logic; flush overrides everything, including a same-cycle accept
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      resolve = 1'b0;
      if (flush) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (br_valid) begin
                  accept  = 1'b1;
                  state_d = psr_wr ? StWaitFlags : StResolve;
               end
            end
            StWaitFlags: begin
               if (!psr_wr) state_d = StResolve;
            end
            StResolve: begin
               resolve = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Condition decode against the live flags (valid once no PSR write is pending)
   always_comb begin
      cond_met = 1'b0;
      case (cond_q)
         4'b0000: cond_met = flg_z;
         4'b0001: cond_met = !flg_z;
         4'b0010: cond_met = flg_c;
         4'b0011: cond_met = !flg_c;
         4'b0100: cond_met = flg_l;
         4'b0101: cond_met = !flg_l;
         4'b0110: cond_met = flg_n;
         4'b0111: cond_met = !flg_n;
         4'b1000: cond_met = flg_f;
         4'b1001: cond_met = !flg_f;
         4'b1010: cond_met = !flg_l && !flg_z;
         4'b1011: cond_met = flg_l || flg_z;
         4'b1100: cond_met = !flg_n && !flg_z;
         4'b1101: cond_met = flg_n || flg_z;
         4'b1110: cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   end

   // Next fetch address, halfword aligned
   always_comb begin
      target    = cond_met ? (pc_q + disp_q) : (pc_q + 16'd2);
      target[0] = 1'b0;
   end

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Request capture on acceptance
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cond_q <= 4'd0;
         pc_q   <= 16'd0;
         disp_q <= 16'd0;
      end else if (accept) begin
         cond_q <= br_cond;
         pc_q   <= br_pc;
         disp_q <= br_disp;
      end
   end

   // Result registers and statistics; the count moves together with res_valid
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         res_valid <= 1'b0;
         res_taken <= 1'b0;
         res_pc    <= 16'd0;
         taken_cnt <= '0;
      end else begin
         res_valid <= resolve;
         if (resolve) begin
            res_taken <= cond_met;
            res_pc    <= target;
            if (cond_met && (taken_cnt != {CNT_W{1'b1}})) taken_cnt <= taken_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: scoreboard of expected resolutions,
// one task per scenario.
module tb_branch_cond_unit;

   localparam int unsigned CNT_W = 8;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             br_valid;
   logic             br_ready;
   logic [3:0]       br_cond;
   logic [15:0]      br_pc;
   logic [15:0]      br_disp;
   logic [4:0]       flag_in;
   logic             psr_wr;
   logic             flush;
   logic             res_valid;
   logic             res_taken;
   logic [15:0]      res_pc;
   logic [CNT_W-1:0] taken_cnt;

   typedef struct packed {
      logic        taken;
      logic [15:0] pc;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   logic [CNT_W-1:0] exp_cnt = '0;
   logic [15:0]      last_pc = 16'd0;

   branch_cond_unit #(.CNT_W(CNT_W)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .br_valid  (br_valid),
      .br_ready  (br_ready),
      .br_cond   (br_cond),
      .br_pc     (br_pc),
      .br_disp   (br_disp),
      .flag_in   (flag_in),
      .psr_wr    (psr_wr),
      .flush     (flush),
      .res_valid (res_valid),
      .res_taken (res_taken),
      .res_pc    (res_pc),
      .taken_cnt (taken_cnt)
   );

   always #5 CLK = ~CLK;

   function automatic logic model_taken(input logic [3:0] c, input logic [4:0] fl);
      logic f, l, cy, n, z;
      {f, l, cy, n, z} = fl;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return l;
         4'h5: return !l;
         4'h6: return n;
         4'h7: return !n;
         4'h8: return f;
         4'h9: return !f;
         4'hA: return !l && !z;
         4'hB: return l || z;
         4'hC: return !n && !z;
         4'hD: return n || z;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] model_pc(input logic tk, input logic [15:0] pc,
                                            input logic [15:0] disp);
      logic [15:0] t;
      t    = tk ? pc + disp : pc + 16'd2;
      t[0] = 1'b0;
      return t;
   endfunction

   // Drive a request at the current (negedge) time and push its expected result,
   // computed from the flags that will be live in the resolve cycle.
   task automatic send(input logic [3:0] c, input logic [15:0] pc, input logic [15:0] disp,
                       input logic [4:0] fl_res);
      exp_t e;
      br_valid = 1'b1;
      br_cond  = c;
      br_pc    = pc;
      br_disp  = disp;
      e.taken  = model_taken(c, fl_res);
      e.pc     = model_pc(e.taken, pc, disp);
      sb.push_back(e);
   endtask

   // Step negedges until res_valid is seen; lat counts cycles since the accept edge.
   task automatic await_res(input int start, output int lat);
      lat = start;
      while (!res_valid && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      if (!res_valid) lat = -1;
   endtask

   task automatic test_reset();
      compared++; if (br_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", br_ready); end
      compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", res_valid); end
      compared++; if (res_taken !== 1'b0) begin mismatched++; $display("FAIL reset_taken: got %b want 0", res_taken); end
      compared++; if (res_pc !== 16'h0000) begin mismatched++; $display("FAIL reset_pc: got %h want 0000", res_pc); end
      compared++; if (taken_cnt !== '0) begin mismatched++; $display("FAIL reset_cnt: got %h want 00", taken_cnt); end
   endtask

   task automatic test_eq_ne();
      exp_t e;
      int   lat;
      flag_in = 5'b00001;
      send(4'h0, 16'h0100, 16'h0010, 5'b00001);
      @(negedge CLK); br_valid = 1'b0;
      await_res(1, lat);
      e = sb.pop_front();
      compared++; if (lat !== 2) begin mismatched++; $display("FAIL eq_latency: got %0d want 2", lat); end
      compared++; if (res_taken !== 1'b1 || e.taken !== 1'b1) begin mismatched++; $display("FAIL eq_taken: got %b want 1", res_taken); end
      compared++; if (res_pc !== 16'h0110) begin mismatched++; $display("FAIL eq_pc: got %h want 0110", res_pc); end
      if (e.taken && exp_cnt != '1) exp_cnt++;
      last_pc = e.pc;
      // NE back-to-back, issued in the res_valid cycle
      compared++; if (br_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready: got %b want 1", br_ready); end
      send(4'h1, 16'hFFFE, 16'h0040, 5'b00001);
      @(negedge CLK); br_valid = 1'b0;
      await_res(1, lat);
      e = sb.pop_front();
      compared++; if (lat !== 2) begin mismatched++; $display("FAIL ne_latency: got %0d want 2", lat); end
      compared++; if (res_taken !== e.taken) begin mismatched++; $display("FAIL ne_taken: got %b want %b", res_taken, e.taken); end
      compared++; if (res_pc !== 16'h0000) begin mismatched++; $display("FAIL ne_wrap_pc: got %h want 0000", res_pc); end
      last_pc = e.pc;
      @(negedge CLK);
      compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL valid_pulse: got %b want 0", res_valid); end
   endtask

   task automatic test_cond_table();
      exp_t       e;
      int         lat;
      logic [4:0] fl;
      for (int k = 0; k < 32; k++) begin
         fl      = 5'($urandom_range(0, 31));
         flag_in = fl;
         if (k > 0) begin
            compared++; if (br_ready !== 1'b1) begin mismatched++; $display("FAIL tbl_ready[%0d]: got %b want 1", k, br_ready); end
         end
         send(4'(k), 16'($urandom), 16'($urandom), fl);
         @(negedge CLK); br_valid = 1'b0;
         await_res(1, lat);
         e = sb.pop_front();
         compared++; if (lat !== 2) begin mismatched++; $display("FAIL tbl_latency[%0d]: got %0d want 2", k, lat); end
         compared++; if (res_taken !== e.taken) begin mismatched++; $display("FAIL tbl_taken[%0d] cond=%h flags=%b: got %b want %b", k, k[3:0], fl, res_taken, e.taken); end
         compared++; if (res_pc !== e.pc) begin mismatched++; $display("FAIL tbl_pc[%0d]: got %h want %h", k, res_pc, e.pc); end
         if (e.taken && exp_cnt != '1) exp_cnt++;
         last_pc = e.pc;
      end
      @(negedge CLK);
      compared++; if (taken_cnt !== exp_cnt) begin mismatched++; $display("FAIL tbl_cnt: got %h want %h", taken_cnt, exp_cnt); end
   endtask

   task automatic test_wait_flags();
      exp_t e;
      int   lat;
      flag_in = 5'b00000;
      psr_wr  = 1'b1;
      send(4'h0, 16'h0200, 16'h0040, 5'b00001);
      @(negedge CLK); br_valid = 1'b0;
      compared++; if (br_ready !== 1'b0) begin mismatched++; $display("FAIL wait_ready: got %b want 0", br_ready); end
      @(negedge CLK);
      compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL wait_early_valid: got %b want 0", res_valid); end
      @(negedge CLK);
      psr_wr  = 1'b0;
      flag_in = 5'b00001;
      await_res(3, lat);
      e = sb.pop_front();
      compared++; if (lat !== 5) begin mismatched++; $display("FAIL wait_latency: got %0d want 5", lat); end
      compared++; if (res_taken !== 1'b1) begin mismatched++; $display("FAIL wait_taken: got %b want 1", res_taken); end
      compared++; if (res_pc !== e.pc) begin mismatched++; $display("FAIL wait_pc: got %h want %h", res_pc, e.pc); end
      if (e.taken && exp_cnt != '1) exp_cnt++;
      last_pc = e.pc;
      @(negedge CLK);
   endtask

   task automatic test_uc_never();
      logic [3:0]  conds [3] = '{4'hE, 4'hF, 4'hE};
      logic [15:0] pcs   [3] = '{16'h0020, 16'h1234, 16'h0101};
      logic [15:0] disps [3] = '{16'hFFF0, 16'h0100, 16'h0004};
      logic [15:0] want  [3] = '{16'h0010, 16'h1236, 16'h0104};
      logic        wtk   [3] = '{1'b1, 1'b0, 1'b1};
      exp_t        e;
      int          lat;
      flag_in = 5'b11111;
      for (int k = 0; k < 3; k++) begin
         send(conds[k], pcs[k], disps[k], flag_in);
         @(negedge CLK); br_valid = 1'b0;
         await_res(1, lat);
         e = sb.pop_front();
         compared++; if (res_taken !== wtk[k]) begin mismatched++; $display("FAIL uc_taken[%0d]: got %b want %b", k, res_taken, wtk[k]); end
         compared++; if (res_pc !== want[k]) begin mismatched++; $display("FAIL uc_pc[%0d]: got %h want %h", k, res_pc, want[k]); end
         if (e.taken && exp_cnt != '1) exp_cnt++;
         last_pc = e.pc;
      end
      @(negedge CLK);
   endtask

   task automatic test_flush();
      logic seen;
      // Flush while in RESOLVE
      br_valid = 1'b1; br_cond = 4'hE; br_pc = 16'h0300; br_disp = 16'h0010;
      @(negedge CLK); br_valid = 1'b0; flush = 1'b1;
      @(negedge CLK); flush = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (res_valid) seen = 1'b1;
         @(negedge CLK);
      end
      compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL flush_resolve_valid: got 1 want 0"); end
      compared++; if (taken_cnt !== exp_cnt) begin mismatched++; $display("FAIL flush_cnt: got %h want %h", taken_cnt, exp_cnt); end
      compared++; if (res_pc !== last_pc) begin mismatched++; $display("FAIL flush_pc_hold: got %h want %h", res_pc, last_pc); end
      // Flush wins over a same-cycle acceptance
      br_valid = 1'b1; flush = 1'b1;
      @(negedge CLK); br_valid = 1'b0; flush = 1'b0;
      compared++; if (br_ready !== 1'b1) begin mismatched++; $display("FAIL flush_prio_ready: got %b want 1", br_ready); end
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (res_valid) seen = 1'b1;
         @(negedge CLK);
      end
      compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL flush_prio_valid: got 1 want 0"); end
   endtask

   task automatic test_reset_mid();
      logic seen;
      psr_wr = 1'b1;
      br_valid = 1'b1; br_cond = 4'hE; br_pc = 16'h0400; br_disp = 16'h0010;
      @(negedge CLK); br_valid = 1'b0;
      #2 RESET = 1'b1;
      #1;
      compared++; if (br_ready !== 1'b1) begin mismatched++; $display("FAIL rst_mid_ready: got %b want 1", br_ready); end
      compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_valid: got %b want 0", res_valid); end
      compared++; if (res_taken !== 1'b0) begin mismatched++; $display("FAIL rst_mid_taken: got %b want 0", res_taken); end
      compared++; if (res_pc !== 16'h0000) begin mismatched++; $display("FAIL rst_mid_pc: got %h want 0000", res_pc); end
      compared++; if (taken_cnt !== '0) begin mismatched++; $display("FAIL rst_mid_cnt: got %h want 00", taken_cnt); end
      @(negedge CLK); RESET = 1'b0; psr_wr = 1'b0;
      exp_cnt = '0; last_pc = 16'h0000;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (res_valid) seen = 1'b1;
         @(negedge CLK);
      end
      compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL rst_mid_no_pulse: got 1 want 0"); end
   endtask

   task automatic test_saturate();
      exp_t e;
      int   lat;
      flag_in = 5'b00000;
      for (int k = 0; k < 300; k++) begin
         send(4'hE, 16'(k * 4), 16'h0008, flag_in);
         @(negedge CLK); br_valid = 1'b0;
         await_res(1, lat);
         e = sb.pop_front();
         compared++; if (lat !== 2 || res_pc !== e.pc) begin mismatched++; $display("FAIL sat_res[%0d]: got lat=%0d pc=%h want lat=2 pc=%h", k, lat, res_pc, e.pc); end
         if (e.taken && exp_cnt != '1) exp_cnt++;
      end
      @(negedge CLK);
      compared++; if (taken_cnt !== 8'hFF) begin mismatched++; $display("FAIL sat_cnt: got %h want ff", taken_cnt); end
      compared++; if (taken_cnt !== exp_cnt) begin mismatched++; $display("FAIL sat_model: got %h want %h", taken_cnt, exp_cnt); end
   endtask

   initial begin
      RESET = 1'b1; br_valid = 1'b0; br_cond = 4'h0; br_pc = 16'h0; br_disp = 16'h0;
      flag_in = 5'b0; psr_wr = 1'b0; flush = 1'b0;
      @(negedge CLK); @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      test_reset();
      test_eq_ne();
      test_cond_table();
      test_wait_flags();
      test_uc_never();
      test_flush();
      test_reset_mid();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
